// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C engine: runs one START/STOP/WRITE/READ command on open-drain SCL/SDA,
// with clock stretching, arbitration-loss detection and bus-busy tracking.
module i2c_bit_ctrl #(
    parameter int PRE_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ena,
    input  logic [PRE_W-1:0] clk_cnt,
    input  logic [1:0]       cmd,
    input  logic             cmd_valid,
    input  logic             din,
    output logic             cmd_ack,
    output logic             dout,
    output logic             busy,
    output logic             al,
    input  logic             scl_i,
    output logic             scl_o,
    output logic             scl_oen_o,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_oen_o
);
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {PH_IDLE, PH_A, PH_B, PH_C, PH_D, PH_E} phase_e;

    phase_e           phase_q, phase_d, ph_nx, last_ph;
    logic [1:0]       cmd_q, cmd_d;
    logic             din_q, din_d;
    logic             scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
    logic             ack_q, ack_d, al_q, al_d, dout_q, dout_d, busy_q;
    logic [PRE_W-1:0] cnt_q;
    logic [1:0]       scl_sync_q;
    logic [2:0]       sda_sync_q;
    logic [1:0]       rel_q;
    logic             scl_s, sda_s, sda_fall, sda_rise;
    logic             stretch, tick, load, arb_sda, arb_stop;

    // {scl_oen, sda_oen} held for the whole of phase ph of command c
    function automatic logic [1:0] lines(input logic [1:0] c, input phase_e ph,
                                         input logic d, input logic scl_keep);
        logic [1:0] r;
        r = 2'b11;
        case (c)
            CMD_START: case (ph)
                PH_A:       r = {scl_keep, 1'b1};
                PH_B:       r = 2'b11;
                PH_C, PH_D: r = 2'b10;
                default:    r = 2'b00;
            endcase
            CMD_STOP: case (ph)
                PH_A:       r = 2'b00;
                PH_B, PH_C: r = 2'b10;
                default:    r = 2'b11;
            endcase
            CMD_WRITE: case (ph)
                PH_B, PH_C: r = {1'b1, d};
                default:    r = {1'b0, d};
            endcase
            default: case (ph)
                PH_B, PH_C: r = 2'b11;
                default:    r = 2'b01;
            endcase
        endcase
        return r;
    endfunction

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign sda_fall = sda_sync_q[2] & ~sda_s & scl_s;
    assign sda_rise = ~sda_sync_q[2] & sda_s & scl_s;

    // Synced SCL lags a release by two cycles; only a low seen after that is a real stretch
    assign stretch = scl_oen_q && (rel_q == 2'd2) && !scl_s;
    assign tick    = (cnt_q == '0) && !stretch;
    assign last_ph = (cmd_q == CMD_START) ? PH_E : PH_D;

    assign arb_sda = sda_oen_q && scl_s && !sda_s &&
                     (((cmd_q == CMD_WRITE) && din_q && (phase_q == PH_B || phase_q == PH_C)) ||
                      ((cmd_q == CMD_START) && (phase_q == PH_B)));
    assign arb_stop = sda_rise && (phase_q != PH_IDLE) && (cmd_q != CMD_STOP);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 3'b111;
            busy_q     <= 1'b0;
            rel_q      <= 2'd2;
            cnt_q      <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            if (sda_fall)
                busy_q <= 1'b1;
            else if (sda_rise)
                busy_q <= 1'b0;
            if (!scl_oen_q)
                rel_q <= 2'd0;
            else if (rel_q != 2'd2)
                rel_q <= rel_q + 2'd1;
            if (load || tick)
                cnt_q <= clk_cnt;
            else if (!stretch)
                cnt_q <= cnt_q - PRE_W'(1);
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cmd_d     = cmd_q;
        din_d     = din_q;
        scl_oen_d = scl_oen_q;
        sda_oen_d = sda_oen_q;
        ack_d     = 1'b0;
        al_d      = 1'b0;
        dout_d    = dout_q;
        load      = 1'b0;
        ph_nx     = PH_IDLE;
        if (!ena) begin
            phase_d   = PH_IDLE;
            scl_oen_d = 1'b1;
            sda_oen_d = 1'b1;
        end else if (phase_q == PH_IDLE) begin
            if (cmd_valid) begin
                cmd_d   = cmd;
                din_d   = din;
                phase_d = PH_A;
                load    = 1'b1;
                {scl_oen_d, sda_oen_d} = lines(cmd, PH_A, din, scl_oen_q);
            end
        end else if (arb_sda || arb_stop) begin
            al_d      = 1'b1;
            phase_d   = PH_IDLE;
            scl_oen_d = 1'b1;
            sda_oen_d = 1'b1;
        end else if (tick) begin
            if (cmd_q == CMD_READ && phase_q == PH_C)
                dout_d = sda_s;
            if (phase_q == last_ph) begin
                phase_d = PH_IDLE;
                ack_d   = 1'b1;
            end else begin
                ph_nx   = phase_e'(phase_q + 3'd1);
                phase_d = ph_nx;
                {scl_oen_d, sda_oen_d} = lines(cmd_q, ph_nx, din_q, scl_oen_q);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_q   <= PH_IDLE;
            cmd_q     <= CMD_START;
            din_q     <= 1'b0;
            scl_oen_q <= 1'b1;
            sda_oen_q <= 1'b1;
            ack_q     <= 1'b0;
            al_q      <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cmd_q     <= cmd_d;
            din_q     <= din_d;
            scl_oen_q <= scl_oen_d;
            sda_oen_q <= sda_oen_d;
            ack_q     <= ack_d;
            al_q      <= al_d;
            dout_q    <= dout_d;
        end
    end

    assign cmd_ack   = ack_q;
    assign al        = al_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign scl_o     = 1'b0;
    assign sda_o     = 1'b0;
    assign scl_oen_o = scl_oen_q;
    assign sda_oen_o = sda_oen_q;

endmodule
